// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory among N_CH valid/ready requesters.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed-priority arbitration.
module mem_port_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int N_CH        = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_CH-1:0]        req_valid,
    input  logic [N_CH-1:0]        req_write,
    input  logic [N_CH*ADDR_W-1:0] req_addr,
    input  logic [N_CH*DATA_W-1:0] req_wdata,
    output logic [N_CH-1:0]        req_ready,
    output logic [N_CH-1:0]        resp_valid,
    output logic [N_CH*DATA_W-1:0] resp_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [1:0]             dbgState
);
    localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;
    // Wait counter is 4 bits wide, so WAIT_STATES is limited to 0..15.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arbStateT;

    arbStateT          state;
    logic [3:0]        waitCnt;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     winner;
    logic              anyValid;
    logic              winWrite;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0]     rrPtr;
`endif

    assign dbgState = state;
    assign anyValid = |req_valid;

    always_comb begin
        winner = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Scan backwards so the channel nearest to rrPtr+1 is written last and wins.
        for (int k = N_CH; k >= 1; k--) begin
            if (req_valid[(int'(rrPtr) + k) % N_CH]) winner = GW'((int'(rrPtr) + k) % N_CH);
        end
`else
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_valid[i]) winner = GW'(i);
        end
`endif
        winWrite = 1'b0;
        winAddr  = '0;
        winWdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (winner == GW'(i)) begin
                winWrite = req_write[i];
                winAddr  = req_addr[i*ADDR_W +: ADDR_W];
                winWdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake: a request transfers in the cycle where req_valid[i] && req_ready[i];
    // ready only rises in IDLE, one-hot on the winner, and a dropped valid costs nothing.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            req_ready[i] = !reset && (state == IDLE) && anyValid && (winner == GW'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            grant      <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rrPtr      <= GW'(N_CH - 1);
`endif
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        grant     <= winner;
                        mem_en    <= 1'b1;
                        mem_we    <= winWrite;
                        mem_addr  <= winAddr;
                        mem_wdata <= winWdata;
                        waitCnt   <= '0;
                        state     <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rrPtr     <= winner;
`endif
                    end
                end
                ACCESS: begin
                    waitCnt <= waitCnt + 4'd1;
                    if (waitCnt == WAIT_LAST) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (grant == GW'(i)) begin
                                resp_valid[i] <= 1'b1;
                                if (!mem_we) resp_rdata[i*DATA_W +: DATA_W] <= mem_rdata;
                            end
                        end
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps on a 2-channel zero-wait instance, then a
// cycle-timeline reference model against a 4-channel, 3-wait-state instance.
module tb_mem_port_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NA  = 2;
    localparam int WSA = 0;
    localparam int NB  = 4;
    localparam int WSB = 3;

    logic clk = 1'b0;
    logic rst;
    int   nPass = 0;
    int   nChecks = 0;

    always #5 clk = ~clk;

    // ---------------- instance A: 2 channels, no wait states ----------------
    logic [NA-1:0]    aValid, aWrite, aReady, aRespValid;
    logic [NA*AW-1:0] aAddr;
    logic [NA*DW-1:0] aWdata, aRespRdata;
    logic             aMemEn, aMemWe;
    logic [AW-1:0]    aMemAddr;
    logic [DW-1:0]    aMemWdata, aMemRdata;
    logic [1:0]       aState;
    logic [DW-1:0]    memA [64];

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NA), .WAIT_STATES(WSA)) dutA (
        .clock(clk), .reset(rst),
        .req_valid(aValid), .req_write(aWrite), .req_addr(aAddr), .req_wdata(aWdata),
        .req_ready(aReady), .resp_valid(aRespValid), .resp_rdata(aRespRdata),
        .mem_en(aMemEn), .mem_we(aMemWe), .mem_addr(aMemAddr), .mem_wdata(aMemWdata),
        .mem_rdata(aMemRdata), .dbgState(aState)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) memA[i] <= 32'h5A5A0000 + 32'(i);
        end else if (aMemEn && aMemWe) begin
            memA[aMemAddr[7:2]] <= aMemWdata;
        end
    end
    assign aMemRdata = memA[aMemAddr[7:2]];

    // ---------------- instance B: 4 channels, 3 wait states ----------------
    logic [NB-1:0]    bValid, bWrite, bReady, bRespValid;
    logic [NB*AW-1:0] bAddr;
    logic [NB*DW-1:0] bWdata, bRespRdata;
    logic             bMemEn, bMemWe;
    logic [AW-1:0]    bMemAddr;
    logic [DW-1:0]    bMemWdata, bMemRdata;
    logic [1:0]       bState;
    logic [DW-1:0]    memB [64];

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_CH(NB), .WAIT_STATES(WSB)) dutB (
        .clock(clk), .reset(rst),
        .req_valid(bValid), .req_write(bWrite), .req_addr(bAddr), .req_wdata(bWdata),
        .req_ready(bReady), .resp_valid(bRespValid), .resp_rdata(bRespRdata),
        .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
        .mem_rdata(bMemRdata), .dbgState(bState)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) memB[i] <= 32'hB0B00000 + 32'(i);
        end else if (bMemEn && bMemWe) begin
            memB[bMemAddr[7:2]] <= bMemWdata;
        end
    end
    assign bMemRdata = memB[bMemAddr[7:2]];

    // ---------------- reference model state for instance B ----------------
    int               mCyc, mIdleAt, mAcc, mCh, mLast;
    bit               mCur, mWr;
    logic [AW-1:0]    mA;
    logic [DW-1:0]    mD, mRdata;
    logic [DW-1:0]    mMem [64];
    logic [NB*DW-1:0] mShadow;
    logic [NB-1:0]    bLastReady;
    logic [NA-1:0]    arbExpA [4];
    logic [NB-1:0]    arbExpB [4];
    logic [NB-1:0]    obsB [4];
    int               nObs;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete access on instance A from a single channel.
    task automatic aRequest(input int ch, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
        int waited;
        int lat;
        aValid = '0;
        aValid[ch] = 1'b1;
        aWrite[ch] = wr;
        aAddr[ch*AW +: AW] = addr;
        aWdata[ch*DW +: DW] = wdata;
        #2;
        waited = 0;
        while (aReady[ch] !== 1'b1 && waited < 10) begin
            cyc(); #2; waited++;
        end
        check("a_ready", 128'(aReady), 128'(NA'(1) << ch));
        cyc(); aValid = '0; #2;
        check("a_mem_en", 128'(aMemEn), 128'(1));
        check("a_mem_we", 128'(aMemWe), 128'(wr));
        check("a_mem_addr", 128'(aMemAddr), 128'(addr));
        if (wr) check("a_mem_wdata", 128'(aMemWdata), 128'(wdata));
        lat = 1;
        while (aRespValid === '0 && lat < 10) begin
            cyc(); #2; lat++;
        end
        check("a_latency", 128'(lat), 128'(2 + WSA));
        check("a_resp_valid", 128'(aRespValid), 128'(NA'(1) << ch));
        cyc(); #2;
        check("a_resp_pulse", 128'(aRespValid), 128'(0));
    endtask

    function automatic int pickB(input logic [NB-1:0] v);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NB; k++) if (v[(mLast + k) % NB]) return (mLast + k) % NB;
`else
        for (int k = 0; k < NB; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    task automatic bModelReset();
        mCyc = 0; mIdleAt = 0; mCur = 0; mLast = NB - 1; mShadow = '0;
        for (int i = 0; i < 64; i++) mMem[i] = 32'hB0B00000 + 32'(i);
    endtask

    task automatic bReset();
        cyc(); rst = 1'b1; bValid = '1; bWrite = '0; #2;
        check("b_rst_ready", 128'(bReady), 128'(0));
        cyc(); #2;
        check("b_rst_ready2", 128'(bReady), 128'(0));
        check("b_rst_mem_en", 128'(bMemEn), 128'(0));
        check("b_rst_resp_valid", 128'(bRespValid), 128'(0));
        check("b_rst_resp_rdata", 128'(bRespRdata), 128'(0));
        check("b_rst_state", 128'(bState), 128'(0));
        cyc(); rst = 1'b0; bValid = '0;
        bModelReset();
    endtask

    // Drive one cycle on instance B and compare every output with the timeline model.
    task automatic bCycle(input logic [NB-1:0] v, input logic [NB-1:0] w,
                          input logic [NB*AW-1:0] ad, input logic [NB*DW-1:0] wd);
        logic [NB-1:0] expReady;
        logic [NB-1:0] expResp;
        bit            expEn;
        int            g;
        cyc();
        bValid = v; bWrite = w; bAddr = ad; bWdata = wd;
        #2;
        expReady = '0;
        g = -1;
        if (mCyc >= mIdleAt && |v) begin
            g = pickB(v);
            expReady[g] = 1'b1;
        end
        expEn = mCur && (mCyc >= mAcc + 1) && (mCyc <= mAcc + 1 + WSB);
        expResp = '0;
        if (mCur && mCyc == mAcc + 2 + WSB) begin
            expResp[mCh] = 1'b1;
            if (!mWr) mShadow[mCh*DW +: DW] = mRdata;
        end
        bLastReady = bReady;
        check("b_req_ready", 128'(bReady), 128'(expReady));
        check("b_mem_en", 128'(bMemEn), 128'(expEn));
        if (expEn) begin
            check("b_mem_we", 128'(bMemWe), 128'(mWr));
            check("b_mem_addr", 128'(bMemAddr), 128'(mA));
            if (mWr) check("b_mem_wdata", 128'(bMemWdata), 128'(mD));
        end
        check("b_resp_valid", 128'(bRespValid), 128'(expResp));
        check("b_resp_rdata", 128'(bRespRdata), 128'(mShadow));
        if (g >= 0) begin
            mCur = 1; mCh = g; mWr = w[g]; mAcc = mCyc; mIdleAt = mCyc + 3 + WSB; mLast = g;
            mA = ad[g*AW +: AW];
            mD = wd[g*DW +: DW];
            if (mWr) mMem[mA[7:2]] = mD;
            mRdata = mMem[mA[7:2]];
        end
        mCyc++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        arbExpA[0] = 2'b01; arbExpA[1] = 2'b10; arbExpA[2] = 2'b01; arbExpA[3] = 2'b10;
        arbExpB[0] = 4'b0001; arbExpB[1] = 4'b0010; arbExpB[2] = 4'b0100; arbExpB[3] = 4'b1000;
`else
        for (int i = 0; i < 4; i++) begin
            arbExpA[i] = 2'b01;
            arbExpB[i] = 4'b0001;
        end
`endif
        for (int i = 0; i < 4; i++) obsB[i] = '0;
        rst = 1'b1;
        aValid = '1; aWrite = '0; aAddr = '0; aWdata = '0;
        bValid = '1; bWrite = '0; bAddr = '0; bWdata = '0;

        // Reset with every channel requesting.
        cyc(); #2;
        check("rst_a_ready", 128'(aReady), 128'(0));
        check("rst_a_mem_en", 128'(aMemEn), 128'(0));
        check("rst_b_ready", 128'(bReady), 128'(0));
        cyc(); #2;
        check("rst_a_state", 128'(aState), 128'(0));
        check("rst_a_resp_rdata", 128'(aRespRdata), 128'(0));
        check("rst_a_mem_addr", 128'(aMemAddr), 128'(0));
        check("rst_a_mem_we", 128'(aMemWe), 128'(0));
        cyc(); rst = 1'b0; bValid = '0; #2;
        check("first_grant", 128'(aReady), 128'(2'b01));
        cyc(); aValid = '0; #2;
        check("first_access_en", 128'(aMemEn), 128'(1));
        cyc(); #2;
        check("first_resp", 128'(aRespValid), 128'(2'b01));
        check("first_rdata", 128'(aRespRdata), 128'({32'h0, 32'h5A5A0000}));

        // Write then read back through ch0, then ch1, checking per-channel hold.
        aRequest(0, 1'b1, 32'h10, 32'hDEADBEEF);
        aRequest(0, 1'b0, 32'h10, 32'h0);
        check("a_rdata_ch0", 128'(aRespRdata), 128'({32'h0, 32'hDEADBEEF}));
        aRequest(1, 1'b1, 32'h24, 32'h12345678);
        aRequest(1, 1'b0, 32'h24, 32'h0);
        check("a_rdata_ch1", 128'(aRespRdata), 128'({32'h12345678, 32'hDEADBEEF}));

        // Both channels held valid: arbitration order and no ready while busy.
        cyc(); aValid = 2'b11; aWrite = '0;
        for (int k = 0; k < 4; k++) begin
            #2; check("a_arb_grant", 128'(aReady), 128'(arbExpA[k]));
            cyc(); #2; check("a_busy_ready", 128'(aReady), 128'(0));
            cyc(); #2; check("a_busy_ready", 128'(aReady), 128'(0));
            cyc();
        end
        aValid = '0;

        // Reset one cycle into ACCESS aborts the access.
        cyc(); aValid = 2'b10; aWrite = '0; aAddr[AW +: AW] = 32'h30; #2;
        check("a_abort_ready", 128'(aReady), 128'(2'b10));
        cyc(); aValid = '0; #2;
        check("a_abort_access", 128'(aMemEn), 128'(1));
        rst = 1'b1;
        cyc(); #2;
        check("a_abort_resp", 128'(aRespValid), 128'(0));
        check("a_abort_state", 128'(aState), 128'(0));
        check("a_abort_mem_en", 128'(aMemEn), 128'(0));
        check("a_abort_rdata", 128'(aRespRdata), 128'(0));
        cyc(); #2;
        check("a_abort_resp2", 128'(aRespValid), 128'(0));
        cyc(); rst = 1'b0; aValid = 2'b10; #2;
        check("a_post_rst_ready", 128'(aReady), 128'(2'b10));
        cyc(); aValid = '0;
        cyc(); #2;
        check("a_post_rst_resp", 128'(aRespValid), 128'(2'b10));
        check("a_post_rst_rdata", 128'(aRespRdata), 128'({32'h5A5A000C, 32'h0}));

        // Instance B: single ch1 read with 3 wait states.
        bReset();
        bCycle(4'b0010, 4'b0000, {32'h0, 32'h0, 32'h40, 32'h0}, '0);
        for (int n = 0; n < 7; n++) bCycle('0, '0, '0, '0);
        check("b_ws_rdata", 128'(bRespRdata), 128'({32'h0, 32'h0, 32'hB0B00010, 32'h0}));

        // All four valid after reset: order including wrap past the last channel.
        bReset();
        nObs = 0;
        for (int n = 0; n < 24; n++) begin
            bCycle('1, '0, '0, '0);
            if (bLastReady != '0 && nObs < 4) begin
                obsB[nObs] = bLastReady;
                nObs++;
            end
        end
        for (int i = 0; i < 4; i++) check("b_grant_order", 128'(obsB[i]), 128'(arbExpB[i]));

        // Randomised traffic against the timeline model.
        for (int n = 0; n < 400; n++) begin
            logic [NB*AW-1:0] ad;
            logic [NB*DW-1:0] wd;
            logic [NB-1:0]    v;
            for (int i = 0; i < NB; i++) begin
                ad[i*AW +: AW] = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                wd[i*DW +: DW] = $urandom;
            end
            v = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom_range(0, 15));
            bCycle(v, NB'($urandom), ad, wd);
        end
        for (int n = 0; n < 8; n++) bCycle('0, '0, '0, '0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
